// File: rtl/controle_es.sv
`default_nettype none
// ============================================================================
//  Module      : controle_es
//  Description : Sequential I/O and halt controller for the single-cycle
//                core. Stalls the PC on `in` and HALT until a debounced
//                operator button press, latches the switches for the `in`
//                write-back and registers the `out` display value.
//                Optional debounce counter: define CONTROLE_ES_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_es #(
  parameter int LARGURA         = 32,
  parameter int LARGURA_CHAVES  = 16,
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [5:0]                opcode,
  input  logic                      botao,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  input  logic [LARGURA-1:0]        dado_saida,
  output logic                      pc_enable,
  output logic                      escreve_in,
  output logic [LARGURA-1:0]        dado_entrada,
  output logic [LARGURA-1:0]        display,
  output logic                      halt_led
);

  localparam logic [5:0] OP_IN   = 6'b000111;
  localparam logic [5:0] OP_HALT = 6'b111110;
  localparam logic [5:0] OP_OUT  = 6'b111000;

  localparam logic [1:0] EXEC        = 2'd0;
  localparam logic [1:0] ESPERA_IN   = 2'd1;
  localparam logic [1:0] ESPERA_HALT = 2'd2;
  localparam logic [1:0] LIBERA      = 2'd3;

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  logic sinc_a;
  logic sinc_b;
  logic valido_a;
  logic valido_b;
  logic nivel;
  logic nivel_ant;
  logic armado;
  logic pressiona;

  // Two-flop synchronizer plus a matching validity pipe that marks when the
  // synchronized value reflects the real button again after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sinc_a   <= 1'b0;
      sinc_b   <= 1'b0;
      valido_a <= 1'b0;
      valido_b <= 1'b0;
    end else begin
      sinc_a   <= botao;
      sinc_b   <= sinc_a;
      valido_a <= 1'b1;
      valido_b <= valido_a;
    end
  end

`ifdef CONTROLE_ES_DEBOUNCE_EN
  localparam int CONT_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic [CONT_W-1:0] contagem;

  // Debouncer: the level rises once DEBOUNCE_CICLOS consecutive high samples
  // are seen; any low sample drops the level and restarts the count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      contagem <= '0;
      nivel    <= 1'b0;
    end else if (!sinc_b) begin
      contagem <= '0;
      nivel    <= 1'b0;
    end else begin
      if (contagem != CONT_MAX) begin
        contagem <= contagem + 1'b1;
      end
      nivel <= (contagem == CONT_MAX);
    end
  end
`else
  // Without the counter the synchronized level is the debounced level.
  assign nivel = sinc_b;
`endif

  // Edge history and arming: a press only counts once the button has been
  // seen released after reset, so a button held through reset never fires.
  always_ff @(posedge clock) begin
    if (!reset) begin
      nivel_ant <= 1'b0;
      armado    <= 1'b0;
    end else begin
      nivel_ant <= nivel;
      if (valido_b && !sinc_b) begin
        armado <= 1'b1;
      end
    end
  end

  assign pressiona = nivel & ~nivel_ant & armado;

  // --------------------------------------------------------------------------
  // Switch zero-extension
  // --------------------------------------------------------------------------
  logic [LARGURA-1:0] chaves_ext;

  if (LARGURA > LARGURA_CHAVES) begin : g_ext_zero
    assign chaves_ext = {{(LARGURA - LARGURA_CHAVES){1'b0}}, chaves};
  end else begin : g_ext_direta
    assign chaves_ext = chaves;
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  logic [1:0] estado;
  logic [1:0] proximo;
  logic       veio_de_in;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= EXEC;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic: wait states are left only on a press; opcode is
  // ignored there.
  always_comb begin
    proximo = estado;
    case (estado)
      EXEC: begin
        if (opcode == OP_IN) begin
          proximo = ESPERA_IN;
        end else if (opcode == OP_HALT) begin
          proximo = ESPERA_HALT;
        end
      end
      ESPERA_IN: begin
        if (pressiona) begin
          proximo = LIBERA;
        end
      end
      ESPERA_HALT: begin
        if (pressiona) begin
          proximo = LIBERA;
        end
      end
      LIBERA: begin
        proximo = EXEC;
      end
      default: begin
        proximo = EXEC;
      end
    endcase
  end

  // Output logic; all strobes are held low while reset is asserted.
  always_comb begin
    pc_enable  = 1'b0;
    halt_led   = 1'b0;
    escreve_in = 1'b0;
    if (reset) begin
      case (estado)
        EXEC: begin
          pc_enable = (opcode != OP_IN) && (opcode != OP_HALT);
        end
        ESPERA_IN, ESPERA_HALT: begin
          halt_led = 1'b1;
        end
        LIBERA: begin
          pc_enable  = 1'b1;
          escreve_in = veio_de_in;
        end
        default: begin
          pc_enable = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------

  // Display register: loaded at the edge that ends an `out` cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      display <= '0;
    end else if ((estado == EXEC) && (opcode == OP_OUT)) begin
      display <= dado_saida;
    end
  end

  // Switch latch and origin flag: the flag tells LIBERA whether the
  // completed wait was an `in` (write-back) or a HALT (no write-back).
  always_ff @(posedge clock) begin
    if (!reset) begin
      dado_entrada <= '0;
      veio_de_in   <= 1'b0;
    end else if ((estado == ESPERA_IN) && pressiona) begin
      dado_entrada <= chaves_ext;
      veio_de_in   <= 1'b1;
    end else if ((estado == ESPERA_HALT) && pressiona) begin
      veio_de_in   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_es.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_es
//  Description : Self-checking bench for controle_es. A behavioural model of
//                the button path (sample history) and the I/O sequencing is
//                compared against the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_es;

  localparam int LARG = 32;
  localparam int LCH  = 16;
  localparam int DEB  = 4;
  localparam int NH   = 8192;

  localparam logic [5:0] OP_IN   = 6'b000111;
  localparam logic [5:0] OP_HALT = 6'b111110;
  localparam logic [5:0] OP_OUT  = 6'b111000;
  localparam logic [5:0] OP_NOP  = 6'b000000;

  logic            clock = 1'b0;
  logic            reset;
  logic [5:0]      opcode;
  logic            botao;
  logic [LCH-1:0]  chaves;
  logic [LARG-1:0] dado_saida;
  logic            pc_enable;
  logic            escreve_in;
  logic [LARG-1:0] dado_entrada;
  logic [LARG-1:0] display;
  logic            halt_led;

  always #5 clock = ~clock;

  controle_es #(
    .LARGURA         (LARG),
    .LARGURA_CHAVES  (LCH),
    .DEBOUNCE_CICLOS (DEB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .botao        (botao),
    .chaves       (chaves),
    .dado_saida   (dado_saida),
    .pc_enable    (pc_enable),
    .escreve_in   (escreve_in),
    .dado_entrada (dado_entrada),
    .display      (display),
    .halt_led     (halt_led)
  );

  int checks = 0;
  int errors = 0;

  // Per-edge history: reset and button samples, and the derived
  // synchronized level, debounced level and armed flag after each edge.
  bit h_rst [NH];
  bit h_b   [NH];
  bit h_f2  [NH];
  bit h_lvl [NH];
  bit h_arm [NH];
  int n;

  typedef enum int {M_RUN, M_WAIT_IN, M_WAIT_HALT, M_DONE} fase_t;
  fase_t           m_fase;
  bit              m_from_in;
  logic [LARG-1:0] m_disp;
  logic [LARG-1:0] m_din;

  task automatic check(input string tag, input logic [LARG-1:0] obs, input logic [LARG-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs present now.
  task automatic model_edge();
    bit p;
    bit lvl;
    p = h_lvl[n] && !h_lvl[n-1] && h_arm[n];
    n++;
    h_rst[n] = !reset;
    h_b[n]   = botao;
    h_f2[n]  = (h_rst[n] || h_rst[n-1]) ? 1'b0 : h_b[n-1];
`ifdef CONTROLE_ES_DEBOUNCE_EN
    lvl = !h_rst[n];
    for (int j = 1; j <= DEB; j++) begin
      lvl = lvl && h_f2[n-j];
    end
`else
    lvl = h_f2[n];
`endif
    h_lvl[n] = lvl;
    h_arm[n] = !h_rst[n] && (h_arm[n-1] || (!h_rst[n-1] && !h_rst[n-2] && !h_b[n-2]));

    if (h_rst[n]) begin
      m_fase    = M_RUN;
      m_from_in = 1'b0;
      m_disp    = '0;
      m_din     = '0;
    end else begin
      case (m_fase)
        M_RUN: begin
          if (opcode == OP_IN) m_fase = M_WAIT_IN;
          else if (opcode == OP_HALT) m_fase = M_WAIT_HALT;
          else if (opcode == OP_OUT) m_disp = dado_saida;
        end
        M_WAIT_IN: begin
          if (p) begin
            m_din     = {{(LARG-LCH){1'b0}}, chaves};
            m_from_in = 1'b1;
            m_fase    = M_DONE;
          end
        end
        M_WAIT_HALT: begin
          if (p) begin
            m_from_in = 1'b0;
            m_fase    = M_DONE;
          end
        end
        default: m_fase = M_RUN;
      endcase
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then
  // let the rising edge happen and update the model.
  task automatic step(input bit rst_n, input bit b, input logic [5:0] op,
                      input logic [LCH-1:0] ch, input logic [LARG-1:0] ds);
    logic e_pc;
    logic e_halt;
    logic e_wr;
    @(negedge clock);
    reset      = rst_n;
    botao      = b;
    opcode     = op;
    chaves     = ch;
    dado_saida = ds;
    #1;
    e_pc   = 1'b0;
    e_halt = 1'b0;
    e_wr   = 1'b0;
    if (rst_n) begin
      e_pc   = (m_fase == M_RUN) ? ((op != OP_IN) && (op != OP_HALT)) : (m_fase == M_DONE);
      e_halt = (m_fase == M_WAIT_IN) || (m_fase == M_WAIT_HALT);
      e_wr   = (m_fase == M_DONE) && m_from_in;
    end
    check("pc_enable", {31'b0, pc_enable}, {31'b0, e_pc});
    check("halt_led", {31'b0, halt_led}, {31'b0, e_halt});
    check("escreve_in", {31'b0, escreve_in}, {31'b0, e_wr});
    check("dado_entrada", dado_entrada, m_din);
    check("display", display, m_disp);
    @(posedge clock);
    model_edge();
  endtask

  initial begin
    logic b_rand;
    logic [5:0] op_rand;
    int r;

    n = 16;
    for (int i = 0; i <= n; i++) h_rst[i] = 1'b1;
    m_fase = M_RUN; m_from_in = 1'b0; m_disp = '0; m_din = '0;

    reset = 1'b0; botao = 1'b1; opcode = OP_IN; chaves = 16'hBEEF; dado_saida = '0;
    @(posedge clock);
    model_edge();

    // Reset held with button pressed and `in` pending
    repeat (3) step(1'b0, 1'b1, OP_IN, 16'hBEEF, 32'h0);
    step(1'b1, 1'b1, OP_IN, 16'hBEEF, 32'h0);
    repeat (8) step(1'b1, 1'b1, OP_NOP, 16'hBEEF, 32'h0);
    repeat (3) step(1'b1, 1'b0, OP_NOP, 16'hBEEF, 32'h0);
    // Press held for 10 cycles
    repeat (10) step(1'b1, 1'b1, OP_NOP, 16'hBEEF, 32'h0);
    repeat (4) step(1'b1, 1'b0, OP_NOP, 16'hBEEF, 32'h0);
    #1;
    check("din_beef", dado_entrada, 32'h0000BEEF);

    // Bouncing press during `in`
    step(1'b1, 1'b0, OP_IN, 16'h1234, 32'h0);
    step(1'b1, 1'b1, OP_NOP, 16'h1234, 32'h0);
    step(1'b1, 1'b0, OP_NOP, 16'h1234, 32'h0);
    step(1'b1, 1'b1, OP_NOP, 16'h1234, 32'h0);
    step(1'b1, 1'b1, OP_NOP, 16'h1234, 32'h0);
    step(1'b1, 1'b0, OP_NOP, 16'h1234, 32'h0);
    repeat (10) step(1'b1, 1'b1, OP_NOP, 16'h1234, 32'h0);
    repeat (4) step(1'b1, 1'b0, OP_NOP, 16'h1234, 32'h0);

    // HALT wait: switches differ but must not be latched
    step(1'b1, 1'b0, OP_HALT, 16'hFFFF, 32'h0);
    repeat (2) step(1'b1, 1'b0, OP_NOP, 16'hFFFF, 32'h0);
    repeat (8) step(1'b1, 1'b1, OP_NOP, 16'hFFFF, 32'h0);
    repeat (4) step(1'b1, 1'b0, OP_NOP, 16'hFFFF, 32'h0);
    #1;
    check("din_after_halt", dado_entrada, 32'h00001234);

    // `out`, nop, then a press in EXEC that must be ignored
    step(1'b1, 1'b0, OP_OUT, 16'h0, 32'h12345678);
    step(1'b1, 1'b0, OP_NOP, 16'h0, 32'h0);
    repeat (8) step(1'b1, 1'b1, OP_NOP, 16'h0, 32'hDEADBEEF);
    repeat (3) step(1'b1, 1'b0, OP_NOP, 16'h0, 32'h0);
    #1;
    check("display_held", display, 32'h12345678);

    // Reset in the middle of an `in` wait
    step(1'b1, 1'b0, OP_IN, 16'h5555, 32'h0);
    repeat (3) step(1'b1, 1'b0, OP_NOP, 16'h5555, 32'h0);
    step(1'b0, 1'b0, OP_NOP, 16'h5555, 32'h0);
    repeat (3) step(1'b1, 1'b0, OP_NOP, 16'h5555, 32'h0);
    #1;
    check("display_after_reset", display, 32'h0);
    check("halt_after_reset", {31'b0, halt_led}, 32'h0);

    // Randomized traffic
    b_rand = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) b_rand = ~b_rand;
      r = $urandom_range(0, 9);
      if (r < 2) op_rand = OP_IN;
      else if (r == 2) op_rand = OP_HALT;
      else if (r < 5) op_rand = OP_OUT;
      else op_rand = 6'($urandom);
      step(($urandom_range(0, 199) != 0), b_rand, op_rand, 16'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controle_es.md
# controle_es

Sequential I/O and halt controller for the single-cycle core. It stalls the PC on `in` (opcode 000111) and `HALT` (opcode 111110) until a debounced operator button press. On `in` it latches the switch value for register-file write-back. On `out` (opcode 111000) it registers the display value. It sits beside the control unit, drives the PC enable, and supplies the data for the in/out write-back mux path.

## Interface
Parameters:
- `LARGURA`, 32, datapath width.
- `LARGURA_CHAVES`, 16, switch bank width; must be ≤ `LARGURA`.
- `DEBOUNCE_CICLOS`, 4, consecutive stable-high cycles required to accept a press; ≥ 1.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `opcode`  in  6  opcode of the current instruction.
- `botao`  in  1  raw operator pushbutton, active-high, asynchronous.
- `chaves`  in  LARGURA_CHAVES  raw switch bank.
- `dado_saida`  in  LARGURA  register-file read data for `out`.
- `pc_enable`  out  1  PC may advance this cycle.
- `escreve_in`  out  1  one-cycle write strobe for `in` write-back.
- `dado_entrada`  out  LARGURA  latched switches, zero-extended.
- `display`  out  LARGURA  output display register.
- `halt_led`  out  1  high while waiting for the operator.

## Operation
- Input conditioning:
  - `botao` passes through a 2-flop synchronizer, then the debouncer.
  - A press pulse (`pressiona`) lasts one cycle, on the rising edge of the debounced level.
  - A held button gives exactly one pulse; the next pulse requires a release first.
- States: EXEC, ESPERA_IN, ESPERA_HALT, LIBERA.
- EXEC:
  - `pc_enable` = 1 unless `opcode` is 000111 or 111110 (combinational from state and opcode).
  - Opcode 000111 → ESPERA_IN.
  - Opcode 111110 → ESPERA_HALT.
  - Opcode 111000 → `display` <= `dado_saida` at this edge; state stays EXEC.
  - All other opcodes: no action.
- ESPERA_IN:
  - `pc_enable` = 0, `halt_led` = 1.
  - On `pressiona` → `dado_entrada` <= zero-extended `chaves` (sampled that edge), then → LIBERA.
- ESPERA_HALT:
  - `pc_enable` = 0, `halt_led` = 1.
  - On `pressiona` → LIBERA; `dado_entrada` is unchanged.
- LIBERA, one cycle:
  - `pc_enable` = 1.
  - `escreve_in` = 1 only if entered from ESPERA_IN.
  - → EXEC.
- `pressiona` in EXEC or LIBERA is discarded, not queued.
- `display` holds until the next `out` or reset. `dado_entrada` holds until the next `in` completes.
- Opcode change while in a wait state is ignored; the FSM only leaves a wait state on a press.
- Reset:
  - Every output is 0 and the state is EXEC.
  - Synchronizer, debounce counter and edge history are cleared.
  - Reset mid-wait abandons the instruction with no `escreve_in` pulse.

## Timing
- `botao` rising before edge k:
  - Debounced level rises at edge k+1+DEBOUNCE_CICLOS.
  - `pressiona` is high in the following cycle.
  - The FSM enters LIBERA at edge k+2+DEBOUNCE_CICLOS.
- Any low sample on the synchronized button restarts the debounce count from 0.
- `out` latency: `display` updates at the edge ending the `out` cycle.
- `escreve_in` and `pc_enable` are high in the same LIBERA cycle, so write-back and PC advance coincide.
- Minimum `in`/HALT duration is DEBOUNCE_CICLOS+3 cycles.

## Configuration
- `CONTROLE_ES_DEBOUNCE_EN` defined:
  - The debounce counter is built.
  - Latency is as given under Timing.
- Not defined:
  - The debounced level is the synchronized level directly and `DEBOUNCE_CICLOS` is ignored.
  - Press-to-LIBERA latency becomes 3 edges (`botao` rising before edge k → LIBERA at edge k+2).
  - All other behaviour is identical.

## Test plan
- Reset held low 3 cycles with `botao`=1, opcode 000111:
  - Outputs are all 0 and state is EXEC throughout.
  - After release, the wait is entered and no pulse occurs while `botao` stays high.
  - The first pulse comes only after a release and a new press.
- `in` with `chaves`=16'hBEEF, press held 10 cycles → `pc_enable`=0 until LIBERA, then `dado_entrada`=32'h0000BEEF and one `escreve_in` pulse coincident with `pc_enable`=1.
- Bounce: `botao` 1,0,1,1,0 then stable 1 with DEBOUNCE_CICLOS=4 → exactly one `pressiona`, 4 cycles after the last low sample plus synchronizer delay.
- HALT (111110), press → `halt_led`=1 while waiting, LIBERA with `escreve_in`=0, `dado_entrada` unchanged.
- `out` with `dado_saida`=32'h12345678, then nop, then press in EXEC → `display`=32'h12345678 held, press ignored, no stall.
- Reset asserted during ESPERA_IN → EXEC next cycle, `halt_led`=0, no `escreve_in`, `display`=0.
